// File: rtl/multdiv_iter.sv
// -----------------------------------------------------------------------------
// multdiv_iter
// Iterative radix-2 multiplier/divider. One request is accepted at a time.
// Each request moves through PREP (operand magnitudes), COMP (WIDTH shift-add
// or restoring-divide steps), FIX (sign correction and result select) and
// DONE (result held until the consumer accepts it).
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   req_valid_i    request present
//   req_ready_o    block is IDLE and can accept a request
//   operator_i     00 MUL (low half), 01 MULH (high half), 10 DIV, 11 REM
//   signed_mode_i  bit0: op_a signed, bit1: op_b signed
//   op_a_i/op_b_i  multiplicand/dividend, multiplier/divisor
//   kill_i         abort the current operation (blocks acceptance in IDLE)
//   res_valid_o    result_o is valid (state DONE)
//   res_ready_i    consumer accepts the result
//   result_o       operation result, held outside DONE
//   busy_o         state is not IDLE
// -----------------------------------------------------------------------------
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, COMP, FIX, DONE} state_e;

    state_e state_q, state_d;

    logic [1:0]       op_q;
    logic [1:0]       sm_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   mag_a_q;
    logic [WIDTH:0]   mag_b_q;
    // hi_q: product high half / partial remainder; lo_q: product low half /
    // dividend bits shifting out while quotient bits shift in.
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;

    // Magnitude on a WIDTH+1 bit datapath so |MIN| = 2^(WIDTH-1) is exact.
    function automatic logic [WIDTH:0] mag_of(input logic [WIDTH-1:0] v,
                                              input logic is_signed);
        logic signed [WIDTH:0] ext;
        ext = $signed({is_signed & v[WIDTH-1], v});
        if (is_signed && v[WIDTH-1]) ext = -ext;
        return ext;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_prod(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? -v : v;
    endfunction

    logic accept;
    logic div_zero;
    logic sign_a, sign_b;

    assign accept   = req_valid_i & req_ready_o & ~kill_i;
    assign div_zero = op_q[1] && (b_q == '0);
    assign sign_a   = a_q[WIDTH-1] & sm_q[0];
    assign sign_b   = b_q[WIDTH-1] & sm_q[1];

    // ---- PREP: operand magnitudes ----
    logic [WIDTH:0] abs_a, abs_b;
    assign abs_a = mag_of(a_q, sm_q[0]);
    assign abs_b = mag_of(b_q, sm_q[1]);

    // ---- COMP: one radix-2 step ----
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    assign mul_sum   = hi_q + (lo_q[0] ? mag_a_q : '0);
    assign div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign div_diff  = div_shift - mag_b_q;
    assign div_ge    = div_shift >= mag_b_q;

    // ---- FIX: sign correction and result select ----
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    assign prod_fix = neg_prod({hi_q[WIDTH-1:0], lo_q}, sign_a ^ sign_b);
    assign quo_fix  = neg_word(lo_q, sign_a ^ sign_b);
    assign rem_fix  = neg_word(hi_q[WIDTH-1:0], sign_a);

    always_comb begin
        fix_res = prod_fix[WIDTH-1:0];
        case (op_q)
            2'b00:   fix_res = prod_fix[WIDTH-1:0];
            2'b01:   fix_res = prod_fix[2*WIDTH-1:WIDTH];
            2'b10:   fix_res = quo_fix;
            default: fix_res = rem_fix;
        endcase
    end

    // ---- state register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = PREP;
                PREP:    state_d = div_zero ? DONE : COMP;
                COMP:    if (cnt_q == '0) state_d = FIX;
                FIX:     state_d = DONE;
                DONE:    if (res_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---- datapath registers ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            sm_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= operator_i;
                        sm_q <= signed_mode_i;
                        a_q  <= op_a_i;
                        b_q  <= op_b_i;
                    end
                end
                PREP: begin
                    if (!kill_i) begin
                        mag_a_q <= abs_a;
                        mag_b_q <= abs_b;
                        hi_q    <= '0;
                        lo_q    <= op_q[1] ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0];
                        cnt_q   <= CNT_W'(WIDTH - 1);
                        // Divide by zero: DIV gives all ones, REM the raw dividend.
                        if (div_zero) result_q <= op_q[0] ? a_q : '1;
                    end
                end
                COMP: begin
                    if (!kill_i) begin
                        if (op_q[1]) begin
                            hi_q <= div_ge ? div_diff : div_shift;
                            lo_q <= {lo_q[WIDTH-2:0], div_ge};
                        end else begin
                            hi_q <= {1'b0, mul_sum[WIDTH:1]};
                            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    if (!kill_i) result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// -----------------------------------------------------------------------------
// tb_multdiv_iter
// Scoreboard bench for multdiv_iter (WIDTH=32). Requests push the expected
// result and latency into a queue; an independent monitor compares whenever
// the DUT presents a result.
// -----------------------------------------------------------------------------
module tb_multdiv_iter;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [1:0]   operator_i = '0;
    logic [1:0]   signed_mode_i = '0;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic         kill_i = 1'b0;
    logic         res_valid_o;
    logic         res_ready_i = 1'b0;
    logic [W-1:0] result_o;
    logic         busy_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit hold_low = 1'b0;
    bit mon_off = 1'b0;
    bit prev_valid = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc;
    } exp_t;
    exp_t sbq[$];

    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    multdiv_iter #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .operator_i   (operator_i),
        .signed_mode_i(signed_mode_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .kill_i       (kill_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .result_o     (result_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on sign/zero-extended operands.
    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [1:0] sm,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic signed [127:0] pa, pb, p;
        sa = sm[0] ? longint'($signed(a)) : longint'(a);
        sb = sm[1] ? longint'($signed(b)) : longint'(b);
        pa = sa;
        pb = sb;
        p  = pa * pb;
        if (op == 2'b00) return p[31:0];
        if (op == 2'b01) return p[63:32];
        if (b == '0) return (op == 2'b10) ? 32'hFFFFFFFF : a;
        q = sa / sb;
        r = sa % sb;
        return (op == 2'b10) ? q[31:0] : r[31:0];
    endfunction

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Consumer ready: random, or forced low.
    initial forever begin
        @(posedge clk_i);
        #2;
        res_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor
    initial forever begin
        @(negedge clk_i);
        if (rst_ni && !mon_off && res_valid_o) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
                if (!prev_valid) check("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                check("result", result_o, sbq[0].res);
                check("ready_in_done", req_ready_o, 0);
                if (res_ready_i) void'(sbq.pop_front());
            end
        end
        prev_valid = res_valid_o;
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!req_ready_o) check("ready_timeout", req_ready_o, 1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!res_valid_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check(name, res_valid_o, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("drain", 64'(sbq.size()), 0);
    endtask

    // Called at posedge+1; returns at accept edge+1.
    task automatic issue(input logic [1:0] op, input logic [1:0] sm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit scored, input bit use_exp, input logic [W-1:0] exp_v);
        exp_t e;
        wait_ready();
        operator_i    = op;
        signed_mode_i = sm;
        op_a_i        = a;
        op_b_i        = b;
        req_valid_i   = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i   = 1'b0;
        operator_i    = 2'($urandom);
        signed_mode_i = 2'($urandom);
        op_a_i        = $urandom;
        op_b_i        = $urandom;
        if (scored) begin
            e.res = use_exp ? exp_v : ref_model(op, sm, a, b);
            e.lat = (op[1] && b == '0) ? 1 : W + 2;
            e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", req_ready_o, 1);
        check("rst_valid", res_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_result", result_o, 0);
        rst_ni = 1'b1;

        // Directed cases with hand-derived results
        issue(2'b00, 2'b11, 32'h7, 32'hFFFFFFFD, 1, 1, 32'hFFFFFFEB);
        issue(2'b01, 2'b11, 32'h80000000, 32'h80000000, 1, 1, 32'h40000000);
        issue(2'b01, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFE);
        issue(2'b10, 2'b11, 32'hFFFFFFF9, 32'h2, 1, 1, 32'hFFFFFFFD);
        issue(2'b11, 2'b11, 32'hFFFFFFF9, 32'h2, 1, 1, 32'hFFFFFFFF);
        issue(2'b10, 2'b00, 32'h5, 32'h0, 1, 1, 32'hFFFFFFFF);
        issue(2'b11, 2'b00, 32'h5, 32'h0, 1, 1, 32'h5);
        issue(2'b11, 2'b11, 32'hFFFFFFF9, 32'h0, 1, 1, 32'hFFFFFFF9);
        issue(2'b10, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'h80000000);
        issue(2'b11, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'h0);
        issue(2'b10, 2'b00, 32'h80000000, 32'h3, 1, 1, 32'h2AAAAAAA);
        drain();

        // Consumer stalls 5 cycles in DONE
        hold_low = 1'b1;
        issue(2'b00, 2'b00, 32'd12345, 32'd678, 1, 1, 32'd8369910);
        wait_valid("stall_valid");
        repeat (5) begin
            @(posedge clk_i); #1;
            check("stall_hold_valid", res_valid_o, 1);
            check("stall_hold_ready", req_ready_o, 0);
        end
        hold_low = 1'b0;
        drain();

        // Kill in COMP cycle 10
        issue(2'b00, 2'b11, $urandom, $urandom, 0, 0, '0);
        repeat (11) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        check("kill_comp_ready", req_ready_o, 1);
        check("kill_comp_valid", res_valid_o, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (res_valid_o) seen = 1'b1;
        end
        check("kill_comp_no_result", seen, 0);
        issue(2'b10, 2'b11, 32'hFFFFFF9C, 32'h7, 1, 1, 32'hFFFFFFF2);
        drain();

        // Kill in DONE discards result
        hold_low = 1'b1;
        mon_off = 1'b1;
        issue(2'b00, 2'b00, 32'h3, 32'h3, 0, 0, '0);
        wait_valid("kill_done_valid");
        kill_i = 1'b1;
        @(posedge clk_i); #1;
        kill_i = 1'b0;
        check("kill_done_valid_low", res_valid_o, 0);
        check("kill_done_ready", req_ready_o, 1);
        mon_off = 1'b0;
        hold_low = 1'b0;

        // Kill in IDLE blocks acceptance
        kill_i = 1'b1;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        check("kill_idle_busy", busy_o, 0);
        check("kill_idle_ready", req_ready_o, 1);
        req_valid_i = 1'b0;
        kill_i = 1'b0;

        // Reset mid-COMP
        issue(2'b01, 2'b01, $urandom, $urandom, 0, 0, '0);
        repeat (10) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("amid_rst_result", result_o, 0);
        check("amid_rst_valid", res_valid_o, 0);
        check("amid_rst_busy", busy_o, 0);
        check("amid_rst_ready", req_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        issue(2'b11, 2'b00, 32'd100, 32'd7, 1, 1, 32'd2);
        drain();

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            issue(2'($urandom), 2'($urandom), pick(), pick(), 1, 0, '0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
